rw_port_arbiter: RTL and testbench
==================================

// Module: rw_port_arbiter
// PURPOSE
//  Shares one single-port memory read/write interface between N_REQ requesters.
//  Uses round-robin arbitration. The mem_read/mem_write strobes are guaranteed low during reset.
//  Sits between requester logic (DMA, CPU shim) and the memory port.
//  Provides per-requester completion pulses and timeout error pulses.
// PARAMETERS
//  N_REQ    2   number of requesters (2..8)
//  AW       8   address width
//  DW       8   data width
//  TIMEOUT  15  max BUSY cycles waiting for mem_ready before abort (>=2)
// PORTS
//  clk        in   1         clock, all logic on posedge
//  reset      in   1         asynchronous, active-high reset
//  req        in   N_REQ     request level, one bit per requester
//  req_we     in   N_REQ     1=write, 0=read, per requester
//  req_addr   in   N_REQ*AW  flattened addresses, requester i at [i*AW +: AW]
//  req_wdata  in   N_REQ*DW  flattened write data, same packing
//  gnt        out  N_REQ     one-hot, high for whole BUSY of granted requester
//  done       out  N_REQ     one-cycle one-hot completion pulse
//  err        out  N_REQ     one-cycle one-hot timeout pulse
//  rdata      out  DW        read data of last completed read, held until next read
//  busy       out  1         high in BUSY
//  mem_read   out  1         memory read strobe
//  mem_write  out  1         memory write strobe
//  mem_addr   out  AW        memory address
//  mem_wdata  out  DW        memory write data
//  mem_rdata  in   DW        memory read data, valid with mem_ready
//  mem_ready  in   1         memory access complete
// BEHAVIOUR
//  Reset: all outputs 0, state=IDLE, rr_ptr=0, timeout counter=0.
//   - Async assert clears immediately.
//   - mem_read/mem_write are 0 for every cycle reset is high.
//  FSM IDLE -> BUSY -> IDLE. All outputs are registered.
//  IDLE:
//   - If |req at a posedge: pick the first set req bit searching rr_ptr, rr_ptr+1, ... (mod N_REQ).
//   - Latch req_we, addr and wdata of the winner.
//   - Go to BUSY and set gnt, busy and exactly one of mem_read/mem_write, effective the next cycle.
//  mem_read and mem_write are never both 1.
//  mem_addr/mem_wdata are stable for the whole BUSY.
//  BUSY, mem_ready=1 at a posedge:
//   - Drop the strobes and gnt, return to IDLE.
//   - Pulse done[winner] for 1 cycle.
//   - If read, rdata <= mem_rdata.
//   - rr_ptr <= (winner+1) mod N_REQ.
//  BUSY, no ready:
//   - Counter increments each cycle.
//   - At TIMEOUT consecutive BUSY cycles without ready: abort to IDLE, pulse err[winner], no done.
//   - rdata is unchanged; rr_ptr advances as on completion.
//   - Counter clears on leaving BUSY.
//  mem_ready together with the timeout cycle: ready wins (done, no err).
//  mem_ready while in IDLE: ignored.
//  req changes or drops during BUSY: ignored, the latched transaction finishes.
//  Throughput: min 2 cycles per access (grant cycle + 1 BUSY cycle). IDLE re-arbitrates on the edge after done.
//  Reset during BUSY: transaction dropped, no done/err, strobes low immediately.
//  Latency: req sampled at edge k -> strobe high from k to k+1.
//   - If mem_ready is sampled at edge k+1+w, done is high from k+1+w to k+2+w.
// TESTING
//  1 reset=1 for 5 cycles, req=2'b11 held -> mem_read=mem_write=0, gnt=0 throughout; first grant is to req[0] after release.
//  2 Single read, req[0], addr=8'h3C, ready one BUSY cycle later, mem_rdata=8'hA5.
//     -> mem_read for exactly 2 cycles with mem_addr=8'h3C; done=2'b01 1 cycle; rdata=8'hA5.
//  3 req=2'b11 held, zero-wait memory -> grants alternate 01,10,01,10; no requester granted twice in a row.
//  4 Write req[1], mem_ready never asserted, TIMEOUT=15.
//     -> mem_write high 15 cycles; err=2'b10 1 cycle; done stays 0; returns IDLE.
//  5 Reset asserted mid-BUSY -> strobes/gnt/busy 0 same time step; no done/err; next grant restarts at rr_ptr=0.
//  6 Assertions all run: !(mem_read&&mem_write); reset |-> !mem_read&&!mem_write; $onehot0(gnt); $onehot0(done|err).

Source files
------------

// File: rtl/rw_port_arbiter.sv
// rtl/rw_port_arbiter.sv - round-robin arbiter sharing one memory read/write port
//
// Purpose: N_REQ requesters share a single-port memory. Each access is granted
// round-robin and held until the memory answers with mem_ready, or until TIMEOUT
// BUSY cycles pass without an answer, in which case the access is aborted.
// Every output is registered.
//
// Ports:
//   clk        clock, all logic on posedge
//   reset      asynchronous, active-high reset
//   req        request level, one bit per requester
//   req_we     1=write, 0=read, per requester
//   req_addr   flattened addresses, requester i at [i*AW +: AW]
//   req_wdata  flattened write data, same packing
//   gnt        one-hot grant, held for the whole BUSY phase
//   done       one-cycle one-hot completion pulse
//   err        one-cycle one-hot timeout pulse
//   rdata      data of the last completed read
//   busy       high while an access is in flight
//   mem_read   memory read strobe
//   mem_write  memory write strobe
//   mem_addr   memory address, stable during BUSY
//   mem_wdata  memory write data, stable during BUSY
//   mem_rdata  memory read data, valid with mem_ready
//   mem_ready  memory access complete

module rw_port_arbiter #(
  parameter int N_REQ   = 2,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic [N_REQ-1:0]    err,
  output logic [DW-1:0]       rdata,
  output logic                busy,
  output logic                mem_read,
  output logic                mem_write,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata,
  input  logic                mem_ready
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_n;
  logic [PW-1:0] rr_ptr, rr_n;
  logic [PW-1:0] winner, winner_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [N_REQ-1:0] gnt_n, done_n, err_n;
  logic [DW-1:0]    rdata_n, wdata_n;
  logic [AW-1:0]    addr_n;
  logic             busy_n, rd_n, wr_n;

  logic [AW-1:0] addr_arr  [N_REQ];
  logic [DW-1:0] wdata_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*AW +: AW];
    assign wdata_arr[g] = req_wdata[g*DW +: DW];
  end

  // Round-robin search: first set request starting at rr_ptr, wrapping mod N_REQ.
  logic          found;
  logic [PW-1:0] win_idx;
  logic [PW:0]   cand;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
      if (!found && req[cand[PW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
  end

  // Pointer position just after the current winner, used on completion and abort.
  logic [PW:0]   adv;
  logic [PW-1:0] rr_after;

  always_comb begin
    adv = {1'b0, winner} + (PW+1)'(1);
    if (adv == (PW+1)'(N_REQ)) adv = '0;
    rr_after = adv[PW-1:0];
  end

  always_comb begin
    state_n  = state;
    rr_n     = rr_ptr;
    winner_n = winner;
    cnt_n    = cnt;
    gnt_n    = gnt;
    done_n   = '0;
    err_n    = '0;
    rdata_n  = rdata;
    busy_n   = busy;
    rd_n     = mem_read;
    wr_n     = mem_write;
    addr_n   = mem_addr;
    wdata_n  = mem_wdata;

    case (state)
      IDLE: begin
        if (found) begin
          state_n  = BUSY;
          winner_n = win_idx;
          cnt_n    = '0;
          gnt_n    = N_REQ'(1) << win_idx;
          busy_n   = 1'b1;
          rd_n     = !req_we[win_idx];
          wr_n     = req_we[win_idx];
          addr_n   = addr_arr[win_idx];
          wdata_n  = wdata_arr[win_idx];
        end
      end
      BUSY: begin
        // cnt holds the number of earlier BUSY cycles without ready, so this
        // edge ends BUSY cycle cnt+1; ready is checked first so it wins a tie.
        if (mem_ready || cnt == CW'(TIMEOUT - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          gnt_n   = '0;
          busy_n  = 1'b0;
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          rr_n    = rr_after;
          if (mem_ready) begin
            done_n = N_REQ'(1) << winner;
            if (mem_read) rdata_n = mem_rdata;
          end else begin
            err_n = N_REQ'(1) << winner;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      winner    <= '0;
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_n;
      winner    <= winner_n;
      cnt       <= cnt_n;
      gnt       <= gnt_n;
      done      <= done_n;
      err       <= err_n;
      rdata     <= rdata_n;
      busy      <= busy_n;
      mem_read  <= rd_n;
      mem_write <= wr_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
    end
  end

endmodule

// File: tb/tb_rw_port_arbiter.sv
// tb/tb_rw_port_arbiter.sv - directed self-checking bench for rw_port_arbiter

module tb_rw_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, req_we;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  gnt, done, err;
  logic [7:0]  rdata;
  logic        busy, mem_read, mem_write;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  rw_port_arbiter #(.N_REQ(2), .AW(8), .DW(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .err(err), .rdata(rdata), .busy(busy), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  a_excl: assert property (@(posedge clk) !(mem_read && mem_write))
    else begin n_fail++; $error("FAIL strobe_excl: read=%0b write=%0b", mem_read, mem_write); end
  a_rst: assert property (@(posedge clk) reset |-> (!mem_read && !mem_write))
    else begin n_fail++; $error("FAIL strobe_in_reset: read=%0b write=%0b", mem_read, mem_write); end
  a_gnt: assert property (@(posedge clk) $onehot0(gnt))
    else begin n_fail++; $error("FAIL gnt_onehot: gnt=%b", gnt); end
  a_pulse: assert property (@(posedge clk) $onehot0(done | err))
    else begin n_fail++; $error("FAIL pulse_onehot: done=%b err=%b", done, err); end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req       = 2'b11;
    req_we    = 2'b00;
    req_addr  = 16'h0000;
    req_wdata = 16'h0000;
    mem_rdata = 8'h00;
    mem_ready = 1'b0;

    // 1: reset held with both requests pending
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_read",  mem_read,  0);
      check("rst_write", mem_write, 0);
      check("rst_gnt",   gnt,       0);
      check("rst_busy",  busy,      0);
    end
    check("rst_done",  done,     0);
    check("rst_err",   err,      0);
    check("rst_rdata", rdata,    0);
    check("rst_addr",  mem_addr, 0);
    reset = 1'b0;
    tick();
    check("first_gnt",  gnt,      2'b01);
    check("first_busy", busy,     1);
    check("first_read", mem_read, 1);
    mem_ready = 1'b1;
    tick();
    check("first_done", done, 2'b01);
    check("first_gnt0", gnt,  2'b00);
    req = 2'b00;
    mem_ready = 1'b0;
    tick();
    check("idle_done0", done, 2'b00);

    // 2: single read of requester 0 with one wait cycle
    req_addr  = 16'h003C;
    mem_rdata = 8'hA5;
    req       = 2'b01;
    tick();
    check("rd_strobe1", mem_read,  1);
    check("rd_write1",  mem_write, 0);
    check("rd_addr1",   mem_addr,  8'h3C);
    check("rd_gnt",     gnt,       2'b01);
    req = 2'b00;
    tick();
    check("rd_strobe2", mem_read, 1);
    check("rd_addr2",   mem_addr, 8'h3C);
    check("rd_done_early", done,  2'b00);
    mem_ready = 1'b1;
    tick();
    check("rd_strobe_off", mem_read, 0);
    check("rd_done",  done,  2'b01);
    check("rd_rdata", rdata, 8'hA5);
    check("rd_busy0", busy,  0);
    mem_ready = 1'b0;
    mem_rdata = 8'h11;
    tick();
    check("rd_done_pulse", done,  2'b00);
    check("rd_rdata_hold", rdata, 8'hA5);

    // 3: both requesting, zero-wait memory; rr_ptr is 1 after the last done
    req = 2'b11;
    mem_ready = 1'b1;
    tick(); check("rr_g1", gnt, 2'b10); check("rr_d1", done, 2'b00);
    tick(); check("rr_g2", gnt, 2'b00); check("rr_d2", done, 2'b10);
    tick(); check("rr_g3", gnt, 2'b01); check("rr_d3", done, 2'b00);
    tick(); check("rr_g4", gnt, 2'b00); check("rr_d4", done, 2'b01);
    tick(); check("rr_g5", gnt, 2'b10);
    tick(); check("rr_d6", done, 2'b10);
    tick(); check("rr_g7", gnt, 2'b01);
    req = 2'b00;
    tick(); check("rr_d8", done, 2'b01);
    check("rr_rdata", rdata, 8'h11);
    mem_ready = 1'b0;
    tick();

    // 4: write from requester 1, memory never answers
    req_we    = 2'b10;
    req_addr  = 16'hC300;
    req_wdata = 16'h5A00;
    req       = 2'b10;
    tick();
    check("to_gnt",   gnt,       2'b10);
    check("to_write", mem_write, 1);
    check("to_read",  mem_read,  0);
    check("to_addr",  mem_addr,  8'hC3);
    check("to_wdata", mem_wdata, 8'h5A);
    req = 2'b00;
    for (int i = 1; i < 15; i++) begin
      tick();
      check("to_write_held", mem_write, 1);
      check("to_err_early",  err,       2'b00);
    end
    tick();
    check("to_write_off", mem_write, 0);
    check("to_err",       err,       2'b10);
    check("to_no_done",   done,      2'b00);
    check("to_busy0",     busy,      0);
    check("to_rdata",     rdata,     8'h11);
    tick();
    check("to_err_pulse", err, 2'b00);
    check("to_idle_gnt",  gnt, 2'b00);

    // 5: reset in the middle of BUSY; first move rr_ptr to 1
    req_we    = 2'b00;
    req       = 2'b01;
    mem_ready = 1'b1;
    tick();
    check("pre_gnt", gnt, 2'b01);
    req = 2'b00;
    tick();
    check("pre_done", done, 2'b01);
    mem_ready = 1'b0;
    req = 2'b11;
    tick();
    check("mid_gnt", gnt, 2'b10);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_read", mem_read, 0);
    check("mid_rst_gnt",  gnt,      2'b00);
    check("mid_rst_busy", busy,     0);
    tick();
    check("mid_rst_done", done, 2'b00);
    check("mid_rst_err",  err,  2'b00);
    reset = 1'b0;
    tick();
    check("post_rst_gnt",  gnt,      2'b01);
    check("post_rst_read", mem_read, 1);
    req = 2'b00;
    mem_ready = 1'b1;
    tick();
    check("post_rst_done", done, 2'b01);
    mem_ready = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
